// File: rtl/gerador_flags.sv
// gerador_flags: ALU status-flag register (z, c, s, o) with per-bit write mask.
// Define GERADOR_FLAGS_PILHA_EN to add the LIFO save stack used on
// interrupt entry (salva) and return (restaura). Without the macro,
// salva/restaura are ignored and nivel_pilha/erro_pilha stay at 0.
module gerador_flags #(
  parameter int unsigned LARGURA = 16,
  parameter int unsigned PROF    = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [LARGURA-1:0]           resultado,
  input  logic                         op_a_msb,
  input  logic                         op_b_msb,
  input  logic                         carry_alu,
  input  logic [1:0]                   tipo_op,
  input  logic                         atualiza,
  input  logic [3:0]                   mascara,
  input  logic                         salva,
  input  logic                         restaura,
  output logic [3:0]                   Flags,
  output logic                         flags_validos,
  output logic [$clog2(PROF+1)-1:0]    nivel_pilha,
  output logic                         erro_pilha
);

  localparam int unsigned NW = $clog2(PROF + 1);

  localparam logic [1:0] OP_LOGICA = 2'b00;
  localparam logic [1:0] OP_SOMA   = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b10;
  localparam logic [1:0] OP_DESLOC = 2'b11;

  logic [3:0] flags_q, flags_d;
  logic       validos_q, validos_d;
  logic       z_c, c_c, s_c, o_c;
  logic [3:0] novos_c;
  logic [3:0] atualizado_c;

  // Candidate flag values from the current ALU result; bit order {o, s, c, z}
  always_comb begin
    z_c = (resultado == '0);
    s_c = resultado[LARGURA-1];
    c_c = 1'b0;
    o_c = 1'b0;
    case (tipo_op)
      OP_SOMA: begin
        c_c = carry_alu;
        o_c = (op_a_msb == op_b_msb) && (s_c != op_a_msb);
      end
      OP_SUB: begin
        c_c = carry_alu;
        o_c = (op_a_msb != op_b_msb) && (s_c != op_a_msb);
      end
      OP_DESLOC: c_c = carry_alu;
      default:   c_c = 1'b0;
    endcase
    novos_c      = {o_c, s_c, c_c, z_c};
    atualizado_c = (flags_q & ~mascara) | (novos_c & mascara);
  end

`ifdef GERADOR_FLAGS_PILHA_EN

  logic [3:0]    pilha_q [PROF];
  logic [3:0]    pilha_d [PROF];
  logic [NW-1:0] nivel_q, nivel_d;
  logic          erro_q, erro_d;
  logic [3:0]    topo_c;

  // Next state: conflict > restore (pop wins over update) > push and/or update
  always_comb begin
    flags_d   = flags_q;
    validos_d = validos_q;
    nivel_d   = nivel_q;
    erro_d    = erro_q;
    pilha_d   = pilha_q;
    topo_c    = '0;
    for (int i = 0; i < int'(PROF); i++) begin
      if (nivel_q == NW'(i + 1)) topo_c = pilha_q[i];
    end
    if (salva && restaura) begin
      erro_d = 1'b1;
    end else if (restaura) begin
      if (nivel_q == '0) begin
        erro_d = 1'b1;
      end else begin
        flags_d   = topo_c;
        validos_d = 1'b1;
        nivel_d   = nivel_q - NW'(1);
      end
    end else begin
      if (salva) begin
        if (nivel_q == NW'(PROF)) begin
          erro_d = 1'b1;
        end else begin
          for (int i = 0; i < int'(PROF); i++) begin
            if (nivel_q == NW'(i)) pilha_d[i] = flags_q;
          end
          nivel_d = nivel_q + NW'(1);
        end
      end
      if (atualiza) begin
        flags_d   = atualizado_c;
        validos_d = 1'b1;
      end
    end
  end

  // Stack storage, level and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PROF); i++) pilha_q[i] <= '0;
      nivel_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(PROF); i++) pilha_q[i] <= pilha_d[i];
      nivel_q <= nivel_d;
      erro_q  <= erro_d;
    end
  end

  assign nivel_pilha = nivel_q;
  assign erro_pilha  = erro_q;

`else

  logic unused_pilha;

  // Without the stack every strobed update is applied
  always_comb begin
    flags_d   = flags_q;
    validos_d = validos_q;
    if (atualiza) begin
      flags_d   = atualizado_c;
      validos_d = 1'b1;
    end
  end

  assign unused_pilha = salva ^ restaura;
  assign nivel_pilha  = '0;
  assign erro_pilha   = 1'b0;

`endif

  // Flag word and valid bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      validos_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      validos_q <= validos_d;
    end
  end

  assign Flags         = flags_q;
  assign flags_validos = validos_q;

endmodule

// File: doc/gerador_flags.md
GERADOR_FLAGS -- requirements
Module: gerador_flags

Interface
REQ-001 SHALL have parameter LARGURA, default 16: ALU result width in bits.
REQ-002 SHALL have parameter PROF, default 2: save-stack depth in entries.
REQ-003 SHALL have port clock  in  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port resultado  in  LARGURA: ALU result.
REQ-006 SHALL have port op_a_msb, op_b_msb  in  1 each: operand sign bits.
REQ-007 SHALL have port carry_alu  in  1: adder carry-out, subtract carry, or shifted-out bit.
REQ-008 SHALL have port tipo_op  in  2: 00 logic, 01 add, 10 sub, 11 shift.
REQ-009 SHALL have port atualiza  in  1: update strobe.
REQ-010 SHALL have port mascara  in  4: per-flag write enable.
REQ-011 SHALL have port salva  in  1: push Flags (interrupt entry).
REQ-012 SHALL have port restaura  in  1: pop Flags (interrupt return).
REQ-013 SHALL have port Flags  out  4: bit0 z, bit1 c, bit2 s, bit3 o; this is the word consumed by the jump-condition tester.
REQ-014 SHALL have port flags_validos  out  1: set by the first update or restore after reset.
REQ-015 SHALL have port nivel_pilha  out  clog2(PROF+1): number of occupied stack entries.
REQ-016 SHALL have port erro_pilha  out  1: sticky stack error.

Function
REQ-017 SHALL compute z = (resultado == 0) and s = resultado[LARGURA-1] for all tipo_op.
REQ-018 SHALL compute c = carry_alu for add, sub and shift, and c = 0 for logic.
REQ-019 SHALL compute o = (a==b)&&(s!=a) for add and o = (a!=b)&&(s!=a) for sub, with a = op_a_msb and b = op_b_msb; o SHALL be 0 for logic and shift.
REQ-020 SHALL write Flags[i] on a rising edge with atualiza=1 only where mascara[i]=1, and hold the other bits; the new value SHALL be visible one cycle after the strobe.
REQ-021 SHALL, on salva=1, push the pre-edge Flags value and increment nivel_pilha.
REQ-022 SHALL, when salva and atualiza are high together, both push the old value and update Flags.
REQ-023 SHALL, on restaura=1, load Flags from the top entry and decrement nivel_pilha.
REQ-024 SHALL give restaura priority when restaura and atualiza are high together: the update is dropped.
REQ-025 SHALL, on salva at nivel_pilha == PROF, perform no push and set erro_pilha.
REQ-026 SHALL, on restaura at nivel_pilha == 0, hold Flags and set erro_pilha.
REQ-027 SHALL, when salva and restaura are high in the same cycle, leave the stack and Flags unchanged (any atualiza is also dropped) and set erro_pilha.
REQ-028 SHALL keep erro_pilha at 1 until reset.
REQ-029 SHALL restore entries in LIFO order.

Reset
REQ-030 SHALL, on reset asserted, immediately clear Flags, flags_validos, nivel_pilha, erro_pilha and all stack entries to 0, without waiting for a clock edge.
REQ-031 SHALL abort any same-cycle update, push or pop when reset is asserted; operation resumes on the first rising edge after reset deasserts.

Configuration
REQ-032 SHALL, with macro GERADOR_FLAGS_PILHA_EN defined, implement the save stack per REQ-021 to REQ-029.
REQ-033 SHALL, with GERADOR_FLAGS_PILHA_EN undefined, ignore salva and restaura, hold nivel_pilha and erro_pilha at 0, and instantiate no stack storage; atualiza SHALL then never be dropped.

Verification
REQ-034 SHALL cover add: resultado=16'h8000, a=0, b=0, carry=0, tipo=01, mascara=4'hF -> next cycle Flags=4'b1100, flags_validos=1.
REQ-035 SHALL cover sub: resultado=16'h0000, a=1, b=1, carry=1, tipo=10, mascara=4'hF -> Flags=4'b0011.
REQ-036 SHALL cover partial mask: from Flags=4'b1100, logic op with resultado=0 and mascara=4'b0001 -> Flags=4'b1101.
REQ-037 SHALL cover stack overflow and LIFO order: salva at Flags 4'b0001, then at 4'b0010 -> nivel=2; third salva -> erro_pilha=1, nivel=2; two restaura -> Flags 4'b0010 then 4'b0001, nivel=0.
REQ-038 SHALL cover underflow and priority: restaura at nivel=0 -> Flags unchanged, erro_pilha=1; restaura plus atualiza with 1 entry -> popped value wins.
REQ-039 SHALL cover asynchronous reset: reset pulsed between clock edges with Flags=4'hF and nivel=1 -> all outputs 0 before the next edge.
